snax_acc_csr_ctrl: RTL and testbench
====================================

SNAX_ACC_CSR_CTRL -- requirements
Module: snax_acc_csr_ctrl

Interface
REQ-001 SHALL have parameter NumRwCsr, default 8: number of read/write configuration CSRs.
REQ-002 SHALL have parameter NumRoCsr, default 2: number of read-only status CSRs sourced by the accelerator.
REQ-003 SHALL have parameter CsrAddrOffset, default 32'h3C0: CSR address of the first RW CSR.
REQ-004 SHALL have parameter RspDepth, default 2: response FIFO depth (>=1).
REQ-005 SHALL have parameter SnaxTcdmPorts, default 24: number of monitored TCDM ports.
REQ-006 SHALL have parameter MaxOutstanding, default 8: maximum in-flight reads per TCDM port.
REQ-007 SHALL have port clk_i, input, 1: the single clock.
REQ-008 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have csr_req_addr_i, input, 32; csr_req_data_i, input, 32; csr_req_write_i, input, 1; csr_req_valid_i, input, 1; csr_req_ready_o, output, 1: CSR request channel.
REQ-010 SHALL have csr_rsp_data_o, output, 32; csr_rsp_valid_o, output, 1; csr_rsp_ready_i, input, 1: CSR read-response channel.
REQ-011 SHALL have csr_reg_o, output, NumRwCsr x 32: current RW CSR values; ro_csr_i, input, NumRoCsr x 32: status values.
REQ-012 SHALL have start_o, output, 1: launch pulse; busy_i, input, 1: accelerator busy.
REQ-013 SHALL have tcdm_q_valid_i, tcdm_q_ready_i, tcdm_q_write_i, tcdm_p_valid_i, input, SnaxTcdmPorts each: TCDM handshake taps.
REQ-014 SHALL have barrier_o, output, 1: high only in IDLE.

Function
REQ-015 SHALL map CsrAddrOffset+i (i<NumRwCsr) to RW CSR i; CsrAddrOffset+NumRwCsr to CTRL; next NumRoCsr addresses to ro_csr_i.
REQ-016 SHALL accept a request when csr_req_valid_i & csr_req_ready_o; reads push one response entry, writes push none.
REQ-017 SHALL drive csr_req_ready_o low when the response FIFO is full (no same-cycle pop bypass) or when a write arrives while state != IDLE.
REQ-018 SHALL present read data on csr_rsp_valid_o no earlier than the cycle after acceptance, in request order; data held stable while valid & !ready.
REQ-019 SHALL return 0 for reads of unmapped addresses and ignore writes to unmapped or read-only addresses.
REQ-020 SHALL read CTRL as {30'b0, err, busy}, busy = (state != IDLE).
REQ-021 SHALL use FSM IDLE -> LAUNCH on accepted CTRL write with data[0]=1; LAUNCH -> BUSY after exactly one cycle with start_o=1; BUSY -> DRAIN when busy_i=0; DRAIN -> IDLE when all outstanding counters are 0.
REQ-022 SHALL, per port, increment the outstanding counter on q_valid & q_ready & !q_write, decrement on p_valid, and hold it on simultaneous increment and decrement.
REQ-023 SHALL saturate counters at MaxOutstanding and at 0; a decrement at 0 or an increment at MaxOutstanding sets the sticky err bit.
REQ-024 SHALL clear err on an accepted CTRL write with data[1]=1.
REQ-025 SHALL keep RW CSRs unchanged outside IDLE.

Reset
REQ-026 SHALL on rst_i, at any time including mid-operation, force state IDLE, RW CSRs 0, counters 0, err 0, FIFO empty, start_o 0, csr_rsp_valid_o 0.
REQ-027 SHALL drive barrier_o 1 and csr_req_ready_o 1 during and after reset.

Configuration
REQ-028 SHALL support macro SNAX_ACC_PERF_CNT_EN; when defined, a 32-bit counter clears on LAUNCH, increments each cycle in BUSY or DRAIN, freezes in IDLE, and reads at the address after the last RO CSR.
REQ-029 SHALL, without SNAX_ACC_PERF_CNT_EN, have no counter logic, and that address SHALL read 0.

Structure
REQ-030 SHALL place the FSM state enum, the CTRL bit positions and the CSR index constants in package snax_acc_csr_ctrl_pkg.
REQ-031 SHALL implement the response queue as sub-module snax_csr_rsp_fifo.

Verification
REQ-032 SHALL cover: write 0xDEAD_BEEF to CsrAddrOffset+3, then read it -> csr_reg_o[3]=0xDEADBEEF; response 0xDEADBEEF one cycle later.
REQ-033 SHALL cover: CTRL write 1 with busy_i held high 10 cycles -> start_o single pulse; barrier_o low until busy_i falls and counters are 0; CTRL reads 1 meanwhile.
REQ-034 SHALL cover: 3 reads issued on port 5 with p_valid delayed after busy_i falls -> state stays DRAIN until third p_valid, then IDLE.
REQ-035 SHALL cover: csr_rsp_ready_i=0 with RspDepth=2 and 3 reads -> third read stalls (ready low) until one pop; data ordering preserved.
REQ-036 SHALL cover: p_valid on an idle port -> err=1 in CTRL; CTRL write 2 -> err=0.
REQ-037 SHALL cover: rst_i asserted in BUSY -> next cycle IDLE, barrier_o=1, csr_reg_o all 0; with SNAX_ACC_PERF_CNT_EN, a 10-cycle BUSY plus 2-cycle DRAIN reads 12.

Source files
------------

// File: rtl/snax_acc_csr_ctrl_pkg.sv
// Shared types and constants for the SNAX accelerator CSR controller:
// FSM states, CTRL register bit positions and CSR index helpers.
package snax_acc_csr_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StBusy,
    StDrain
  } state_e;

  localparam int unsigned CsrW = 32;

  // CTRL write bits
  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlErrClrBit = 1;
  // CTRL read bits
  localparam int unsigned CtrlBusyBit   = 0;
  localparam int unsigned CtrlErrBit    = 1;

  // CSR indices are relative to CsrAddrOffset: RW block, CTRL, RO block, perf.
  function automatic int unsigned ctrl_idx(input int unsigned num_rw);
    return num_rw;
  endfunction

  function automatic int unsigned ro_idx(input int unsigned num_rw, input int unsigned i);
    return num_rw + 1 + i;
  endfunction

  function automatic int unsigned perf_idx(input int unsigned num_rw, input int unsigned num_ro);
    return num_rw + 1 + num_ro;
  endfunction

endpackage

// File: rtl/snax_acc_csr_ctrl_rsp_fifo.sv
// Read-response queue for the CSR controller: in-order FIFO, no pop-to-push
// bypass, so full_o depends only on the stored entry count.
module snax_csr_rsp_fifo
  import snax_acc_csr_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = CsrW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  input  logic             ready_i
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign data_o  = mem_q[rptr_q];
  assign pop     = valid_o & ready_i;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= ptr_inc(wptr_q);
      if (pop)    rptr_q <= ptr_inc(rptr_q);
      case ({push_i, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/snax_acc_csr_ctrl.sv
// SNAX accelerator CSR controller: RW/RO CSR file, launch FSM and TCDM
// outstanding-read tracking. Optional busy-cycle counter: SNAX_ACC_PERF_CNT_EN.
module snax_acc_csr_ctrl
  import snax_acc_csr_ctrl_pkg::*;
#(
  parameter int unsigned NumRwCsr       = 8,
  parameter int unsigned NumRoCsr       = 2,
  parameter logic [31:0] CsrAddrOffset  = 32'h3C0,
  parameter int unsigned RspDepth       = 2,
  parameter int unsigned SnaxTcdmPorts  = 24,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [31:0]                      csr_req_addr_i,
  input  logic [31:0]                      csr_req_data_i,
  input  logic                             csr_req_write_i,
  input  logic                             csr_req_valid_i,
  output logic                             csr_req_ready_o,
  output logic [31:0]                      csr_rsp_data_o,
  output logic                             csr_rsp_valid_o,
  input  logic                             csr_rsp_ready_i,
  output logic [NumRwCsr-1:0][31:0]        csr_reg_o,
  input  logic [NumRoCsr-1:0][31:0]        ro_csr_i,
  output logic                             start_o,
  input  logic                             busy_i,
  input  logic [SnaxTcdmPorts-1:0]         tcdm_q_valid_i,
  input  logic [SnaxTcdmPorts-1:0]         tcdm_q_ready_i,
  input  logic [SnaxTcdmPorts-1:0]         tcdm_q_write_i,
  input  logic [SnaxTcdmPorts-1:0]         tcdm_p_valid_i,
  output logic                             barrier_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  state_e                                state_q;
  logic                                  start_q, barrier_q, err_q, err_d;
  logic [NumRwCsr-1:0][31:0]             csr_q;
  logic [SnaxTcdmPorts-1:0][CntW-1:0]    cnt_q, cnt_d;
  logic [SnaxTcdmPorts-1:0]              inc, dec;
  logic                                  err_set, cnt_idle;
  logic [31:0]                           off, rd_data, ctrl_rd;
  logic                                  fifo_full, req_fire, rd_push, wr_fire, ctrl_wr;

  assign off             = csr_req_addr_i - CsrAddrOffset;
  assign csr_req_ready_o = !fifo_full && !(csr_req_write_i && (state_q != StIdle));
  assign req_fire        = csr_req_valid_i && csr_req_ready_o;
  assign rd_push         = req_fire && !csr_req_write_i;
  assign wr_fire         = req_fire && csr_req_write_i;
  assign ctrl_wr         = wr_fire && (off == 32'(ctrl_idx(NumRwCsr)));
  assign csr_reg_o       = csr_q;
  assign start_o         = start_q;
  assign barrier_o       = barrier_q;

`ifdef SNAX_ACC_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                         perf_q <= '0;
    else if (state_q == StLaunch)                      perf_q <= '0;
    else if (state_q == StBusy || state_q == StDrain)  perf_q <= perf_q + 32'd1;
  end
`endif

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CtrlBusyBit] = (state_q != StIdle);
    ctrl_rd[CtrlErrBit]  = err_q;
  end

  // Unmapped addresses fall through to the zero default.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NumRwCsr; i++)
      if (off == 32'(i)) rd_data = csr_q[i];
    if (off == 32'(ctrl_idx(NumRwCsr))) rd_data = ctrl_rd;
    for (int unsigned i = 0; i < NumRoCsr; i++)
      if (off == 32'(ro_idx(NumRwCsr, i))) rd_data = ro_csr_i[i];
`ifdef SNAX_ACC_PERF_CNT_EN
    if (off == 32'(perf_idx(NumRwCsr, NumRoCsr))) rd_data = perf_q;
`endif
  end

  snax_csr_rsp_fifo #(
    .Depth (RspDepth),
    .Width (32)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rd_push),
    .data_i  (rd_data),
    .full_o  (fifo_full),
    .valid_o (csr_rsp_valid_o),
    .data_o  (csr_rsp_data_o),
    .ready_i (csr_rsp_ready_i)
  );

  // Writes are only accepted in IDLE, so RW CSRs cannot change mid-run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csr_q <= '0;
    end else if (wr_fire) begin
      for (int unsigned i = 0; i < NumRwCsr; i++)
        if (off == 32'(i)) csr_q[i] <= csr_req_data_i;
    end
  end

  assign inc = tcdm_q_valid_i & tcdm_q_ready_i & ~tcdm_q_write_i;
  assign dec = tcdm_p_valid_i;

  always_comb begin
    cnt_d   = cnt_q;
    err_set = 1'b0;
    for (int unsigned p = 0; p < SnaxTcdmPorts; p++) begin
      if (inc[p] && !dec[p]) begin
        if (cnt_q[p] == CntMax) err_set = 1'b1;
        else                    cnt_d[p] = cnt_q[p] + 1'b1;
      end else if (dec[p] && !inc[p]) begin
        if (cnt_q[p] == '0) err_set = 1'b1;
        else                cnt_d[p] = cnt_q[p] - 1'b1;
      end
    end
    err_d = err_q;
    if (ctrl_wr && csr_req_data_i[CtrlErrClrBit]) err_d = 1'b0;
    if (err_set)                                  err_d = 1'b1;
  end

  assign cnt_idle = (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      barrier_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: if (ctrl_wr && csr_req_data_i[CtrlStartBit]) begin
          state_q   <= StLaunch;
          start_q   <= 1'b1;
          barrier_q <= 1'b0;
        end
        StLaunch: begin
          state_q <= StBusy;
          start_q <= 1'b0;
        end
        StBusy: if (!busy_i) state_q <= StDrain;
        StDrain: if (cnt_idle) begin
          state_q   <= StIdle;
          barrier_q <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          start_q   <= 1'b0;
          barrier_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snax_acc_csr_ctrl.sv
// Directed bench for snax_acc_csr_ctrl: CSR access, back-pressure, launch/drain
// FSM, error flag, mid-run reset and the optional SNAX_ACC_PERF_CNT_EN counter.
module tb_snax_acc_csr_ctrl;

  localparam logic [31:0] OFF    = 32'h3C0;
  localparam logic [31:0] A_CTRL = OFF + 32'd8;
  localparam logic [31:0] A_RO0  = OFF + 32'd9;
  localparam logic [31:0] A_RO1  = OFF + 32'd10;
  localparam logic [31:0] A_PERF = OFF + 32'd11;
`ifdef SNAX_ACC_PERF_CNT_EN
  localparam logic [31:0] PERF_EXP = 32'd12;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      req_addr, req_data;
  logic             req_write, req_valid, req_ready;
  logic [31:0]      rsp_data;
  logic             rsp_valid, rsp_ready;
  logic [7:0][31:0] csr_reg;
  logic [1:0][31:0] ro_csr;
  logic             start, busy, barrier;
  logic [23:0]      q_valid, q_ready, q_write, p_valid;

  int n_assert = 0;
  int n_fail   = 0;
  int n_start  = 0;

  always #5 clk = ~clk;

  snax_acc_csr_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .csr_req_addr_i  (req_addr),
    .csr_req_data_i  (req_data),
    .csr_req_write_i (req_write),
    .csr_req_valid_i (req_valid),
    .csr_req_ready_o (req_ready),
    .csr_rsp_data_o  (rsp_data),
    .csr_rsp_valid_o (rsp_valid),
    .csr_rsp_ready_i (rsp_ready),
    .csr_reg_o       (csr_reg),
    .ro_csr_i        (ro_csr),
    .start_o         (start),
    .busy_i          (busy),
    .tcdm_q_valid_i  (q_valid),
    .tcdm_q_ready_i  (q_ready),
    .tcdm_q_write_i  (q_write),
    .tcdm_p_valid_i  (p_valid),
    .barrier_o       (barrier)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [31:0] a, input logic [31:0] d);
    req_addr = a; req_data = d; req_write = 1'b1; req_valid = 1'b1;
    #1;
    for (int w = 0; w < 20 && !req_ready; w++) tick();
    chk("wr_accept", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic csr_read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    req_addr = a; req_write = 1'b0; req_valid = 1'b1;
    #1;
    for (int w = 0; w < 20 && !req_ready; w++) tick();
    tick();
    req_valid = 1'b0;
    chk({tag, "_vld"}, {31'b0, rsp_valid}, 32'd1);
    chk(tag, rsp_data, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_addr = '0; req_data = '0; req_write = 1'b0; req_valid = 1'b0;
    rsp_ready = 1'b1; busy = 1'b0;
    ro_csr = {32'hA5A5_0002, 32'hA5A5_0001};
    q_valid = '0; q_ready = '0; q_write = '0; p_valid = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_barrier", {31'b0, barrier}, 32'd1);
    chk("rst_ready",   {31'b0, req_ready}, 32'd1);
    chk("rst_rspvld",  {31'b0, rsp_valid}, 32'd0);
    chk("rst_start",   {31'b0, start}, 32'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) chk("rst_csr", csr_reg[i], 32'd0);

    // RW/RO/unmapped access
    csr_write(OFF + 32'd3, 32'hDEAD_BEEF);
    chk("csr3_reg", csr_reg[3], 32'hDEAD_BEEF);
    csr_read_chk("rd_csr3", OFF + 32'd3, 32'hDEAD_BEEF);
    csr_write(OFF, 32'h1234_5678);
    csr_write(A_RO0, 32'hFFFF_FFFF);
    csr_read_chk("rd_ro0", A_RO0, 32'hA5A5_0001);
    csr_read_chk("rd_ro1", A_RO1, 32'hA5A5_0002);
    csr_read_chk("rd_unmapped_lo", OFF - 32'd4, 32'd0);
    csr_write(OFF + 32'd20, 32'h0000_0001);
    csr_read_chk("rd_unmapped_hi", OFF + 32'd20, 32'd0);
    chk("csr0_kept", csr_reg[0], 32'h1234_5678);
    csr_read_chk("rd_ctrl_idle", A_CTRL, 32'd0);

    // Response back-pressure with a 2-deep FIFO
    rsp_ready = 1'b0;
    req_addr = OFF; req_write = 1'b0; req_valid = 1'b1;
    #1 chk("bp_rdy0", {31'b0, req_ready}, 32'd1);
    tick();
    req_addr = OFF + 32'd3;
    #1 chk("bp_rdy1", {31'b0, req_ready}, 32'd1);
    tick();
    req_addr = A_RO1;
    #1 chk("bp_stall0", {31'b0, req_ready}, 32'd0);
    chk("bp_head0", rsp_data, 32'h1234_5678);
    tick();
    #1 chk("bp_stall1", {31'b0, req_ready}, 32'd0);
    chk("bp_hold", rsp_data, 32'h1234_5678);
    rsp_ready = 1'b1;
    #1 chk("bp_nobypass", {31'b0, req_ready}, 32'd0);
    tick();
    rsp_ready = 1'b0;
    #1 chk("bp_rdy2", {31'b0, req_ready}, 32'd1);
    chk("bp_head1", rsp_data, 32'hDEAD_BEEF);
    tick();
    req_valid = 1'b0; rsp_ready = 1'b1;
    #1 chk("bp_head1b", rsp_data, 32'hDEAD_BEEF);
    tick();
    chk("bp_head2", rsp_data, 32'hA5A5_0002);
    chk("bp_vld2", {31'b0, rsp_valid}, 32'd1);
    tick();
    chk("bp_empty", {31'b0, rsp_valid}, 32'd0);

    // Error flag: underflow, clear, overflow at MaxOutstanding
    p_valid[2] = 1'b1; tick(); p_valid[2] = 1'b0;
    csr_read_chk("err_underflow", A_CTRL, 32'd2);
    csr_write(A_CTRL, 32'd2);
    csr_read_chk("err_cleared", A_CTRL, 32'd0);
    q_valid[7] = 1'b1; q_ready[7] = 1'b1;
    repeat (8) tick();
    q_valid[7] = 1'b0;
    csr_read_chk("err_at_max", A_CTRL, 32'd0);
    q_valid[7] = 1'b1; tick(); q_valid[7] = 1'b0; q_ready[7] = 1'b0;
    csr_read_chk("err_overflow", A_CTRL, 32'd2);
    p_valid[7] = 1'b1; repeat (8) tick(); p_valid[7] = 1'b0;
    csr_write(A_CTRL, 32'd2);
    csr_read_chk("err_clr2", A_CTRL, 32'd0);

    // Launch with busy held: single start pulse, write stall, CTRL busy
    busy = 1'b1;
    csr_write(A_CTRL, 32'd1);
    chk("launch_start", {31'b0, start}, 32'd1);
    chk("launch_barrier", {31'b0, barrier}, 32'd0);
    tick();
    chk("start_once", {31'b0, start}, 32'd0);
    csr_read_chk("ctrl_busy", A_CTRL, 32'd1);
    req_addr = OFF + 32'd3; req_data = 32'd0; req_write = 1'b1; req_valid = 1'b1;
    #1 chk("busy_wr_stall", {31'b0, req_ready}, 32'd0);
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    chk("busy_csr_kept", csr_reg[3], 32'hDEAD_BEEF);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (start) n_start++;
    end
    chk("no_restart", n_start, 32'd0);
    chk("busy_barrier", {31'b0, barrier}, 32'd0);
    busy = 1'b0;
    tick();
    chk("drain_barrier", {31'b0, barrier}, 32'd0);
    tick();
    chk("idle_barrier", {31'b0, barrier}, 32'd1);
    csr_read_chk("ctrl_idle2", A_CTRL, 32'd0);

    // Drain waits for three outstanding reads on port 5
    busy = 1'b1;
    csr_write(A_CTRL, 32'd1);
    q_valid[5] = 1'b1; q_ready[5] = 1'b1;
    repeat (3) tick();
    q_valid[5] = 1'b0; q_ready[5] = 1'b0;
    busy = 1'b0;
    repeat (3) tick();
    chk("drain0", {31'b0, barrier}, 32'd0);
    p_valid[5] = 1'b1; tick(); p_valid[5] = 1'b0;
    repeat (2) tick();
    chk("drain1", {31'b0, barrier}, 32'd0);
    p_valid[5] = 1'b1; tick(); p_valid[5] = 1'b0;
    tick();
    chk("drain2", {31'b0, barrier}, 32'd0);
    p_valid[5] = 1'b1; tick(); p_valid[5] = 1'b0;
    chk("drain3", {31'b0, barrier}, 32'd0);
    tick();
    chk("drain_done", {31'b0, barrier}, 32'd1);
    csr_read_chk("drain_noerr", A_CTRL, 32'd0);

    // Asynchronous reset while BUSY with a response pending
    busy = 1'b1;
    csr_write(A_CTRL, 32'd1);
    tick();
    rsp_ready = 1'b0;
    req_addr = OFF; req_write = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mrst_barrier", {31'b0, barrier}, 32'd1);
    chk("mrst_ready",   {31'b0, req_ready}, 32'd1);
    chk("mrst_rspvld",  {31'b0, rsp_valid}, 32'd0);
    chk("mrst_start",   {31'b0, start}, 32'd0);
    chk("mrst_csr0",    csr_reg[0], 32'd0);
    chk("mrst_csr3",    csr_reg[3], 32'd0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    csr_read_chk("mrst_ctrl", A_CTRL, 32'd0);

    // 10 cycles BUSY + 2 cycles DRAIN for the busy-cycle counter
    csr_write(A_CTRL, 32'd1);
    q_valid[0] = 1'b1; q_ready[0] = 1'b1;
    tick();
    q_valid[0] = 1'b0; q_ready[0] = 1'b0;
    repeat (9) tick();
    busy = 1'b0;
    tick();
    chk("perf_drain0", {31'b0, barrier}, 32'd0);
    p_valid[0] = 1'b1; tick(); p_valid[0] = 1'b0;
    chk("perf_drain1", {31'b0, barrier}, 32'd0);
    tick();
    chk("perf_idle", {31'b0, barrier}, 32'd1);
    csr_read_chk("perf_cnt", A_PERF, PERF_EXP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
